// File: rtl/ariane_axi_pkg.sv
// Slice of the ariane_axi struct types: the AXI channel payloads and the
// bundled request/response structs that the arbiter forwards.
package ariane_axi;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef logic [3:0]  id_t;
  typedef logic [63:0] addr_t;
  typedef logic [63:0] data_t;
  typedef logic [7:0]  strb_t;

  typedef struct packed {
    id_t        id;
    addr_t      addr;
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
  } aw_chan_t;

  typedef struct packed {
    id_t        id;
    addr_t      addr;
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
  } ar_chan_t;

  typedef struct packed {
    data_t data;
    strb_t strb;
    logic  last;
  } w_chan_t;

  typedef struct packed {
    id_t        id;
    logic [1:0] resp;
  } b_chan_t;

  typedef struct packed {
    id_t        id;
    data_t      data;
    logic [1:0] resp;
    logic       last;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } resp_t;

endpackage

// File: rtl/axi_lock_arbiter_pkg.sv
// Shared round-robin helpers for the lock arbiter; sized for up to
// MaxMasters requesters so one function serves every instance width.
package axi_lock_arbiter_pkg;

  localparam int MaxMasters = 8;

  typedef logic [2:0]            arb_idx_t;
  typedef logic [MaxMasters-1:0] arb_req_t;

  // Winner is the first set bit at or after prio, wrapping at n.
  function automatic arb_idx_t rr_arb_idx(input arb_req_t req, input arb_idx_t prio,
                                          input int n);
    arb_idx_t   win;
    logic [3:0] idx;
    win = '0;
    for (int i = MaxMasters - 1; i >= 0; i--) begin
      if (i < n) begin
        idx = {1'b0, prio} + 4'(i);
        if (idx >= 4'(n)) idx = idx - 4'(n);
        if (req[idx[2:0]]) win = idx[2:0];
      end
    end
    return win;
  endfunction

  function automatic arb_idx_t rr_next_idx(input arb_idx_t idx, input int n);
    return (int'(idx) >= n - 1) ? '0 : idx + 3'd1;
  endfunction

endpackage

// File: rtl/axi_lock_arbiter_rr.sv
// Combinational round-robin picker: returns the index of the first
// requester at or after the priority pointer.
module axi_lock_arbiter_rr
  import axi_lock_arbiter_pkg::*;
#(
  parameter int unsigned NrMasters = 2,
  parameter int unsigned IdxW      = $clog2(NrMasters)
) (
  input  logic [NrMasters-1:0] req,
  input  logic [IdxW-1:0]      prio,
  output logic [IdxW-1:0]      gnt,
  output logic                 any_req
);

  arb_req_t req_ext;

  always_comb begin
    req_ext = '0;
    req_ext[NrMasters-1:0] = req;
  end

  assign gnt     = IdxW'(rr_arb_idx(req_ext, arb_idx_t'(prio), int'(NrMasters)));
  assign any_req = |req;

endmodule

// File: rtl/axi_lock_arbiter.sv
// Shares one AXI master port between NrMasters requesters; reads and writes
// are each locked to one winner for a single transaction.
module axi_lock_arbiter
  import axi_lock_arbiter_pkg::*;
#(
  parameter int unsigned NrMasters = 2,
  parameter int unsigned IdxW      = $clog2(NrMasters)
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  ariane_axi::req_t  [NrMasters-1:0] slv_req_i,
  output ariane_axi::resp_t [NrMasters-1:0] slv_resp_o,
  output ariane_axi::req_t                   mst_req_o,
  input  ariane_axi::resp_t                  mst_resp_i,
  output logic                               rd_busy_o,
  output logic                               wr_busy_o
);

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_e;
  typedef enum logic [1:0] {W_IDLE, W_FWD, W_RESP}  wr_state_e;

  rd_state_e        rd_state_q, rd_state_d;
  wr_state_e        wr_state_q, wr_state_d;
  logic [IdxW-1:0]  rd_gnt_q, rd_gnt_d, rd_prio_q, rd_prio_d;
  logic [IdxW-1:0]  wr_gnt_q, wr_gnt_d, wr_prio_q, wr_prio_d;
  logic             aw_done_q, aw_done_d, w_done_q, w_done_d;

  logic [NrMasters-1:0] ar_req_vec, aw_req_vec;
  logic [IdxW-1:0]      rd_pick, wr_pick;
  logic                 rd_any, wr_any;

  ariane_axi::req_t rd_req_s, wr_req_s;
  logic rd_addr_ph, rd_data_ph, wr_fwd_ph, wr_resp_ph;
  logic ar_hs, r_last_hs, aw_hs, w_last_hs, b_hs;

  always_comb begin
    ar_req_vec = '0;
    aw_req_vec = '0;
    for (int i = 0; i < NrMasters; i++) begin
      ar_req_vec[i] = slv_req_i[i].ar_valid;
      aw_req_vec[i] = slv_req_i[i].aw_valid;
    end
  end

  axi_lock_arbiter_rr #(.NrMasters(NrMasters), .IdxW(IdxW)) u_rd_rr (
    .req     (ar_req_vec),
    .prio    (rd_prio_q),
    .gnt     (rd_pick),
    .any_req (rd_any)
  );

  // W-only requests never win: the write lock opens on AW.
  axi_lock_arbiter_rr #(.NrMasters(NrMasters), .IdxW(IdxW)) u_wr_rr (
    .req     (aw_req_vec),
    .prio    (wr_prio_q),
    .gnt     (wr_pick),
    .any_req (wr_any)
  );

  assign rd_req_s = slv_req_i[rd_gnt_q];
  assign wr_req_s = slv_req_i[wr_gnt_q];

  // Phases fold in reset so every valid/ready drops while rst_i is high.
  assign rd_addr_ph = !rst_i && (rd_state_q == R_ADDR);
  assign rd_data_ph = !rst_i && (rd_state_q == R_DATA);
  assign wr_fwd_ph  = !rst_i && (wr_state_q == W_FWD);
  assign wr_resp_ph = !rst_i && (wr_state_q == W_RESP);

  assign ar_hs     = rd_addr_ph & rd_req_s.ar_valid & mst_resp_i.ar_ready;
  assign r_last_hs = rd_data_ph & mst_resp_i.r_valid & rd_req_s.r_ready & mst_resp_i.r.last;
  assign aw_hs     = wr_fwd_ph & ~aw_done_q & wr_req_s.aw_valid & mst_resp_i.aw_ready;
  assign w_last_hs = wr_fwd_ph & ~w_done_q & wr_req_s.w_valid & mst_resp_i.w_ready
                     & wr_req_s.w.last;
  assign b_hs      = wr_resp_ph & mst_resp_i.b_valid & wr_req_s.b_ready;

  assign rd_busy_o = !rst_i && (rd_state_q != R_IDLE);
  assign wr_busy_o = !rst_i && (wr_state_q != W_IDLE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_state_q <= R_IDLE;
      wr_state_q <= W_IDLE;
      rd_gnt_q   <= '0;
      rd_prio_q  <= '0;
      wr_gnt_q   <= '0;
      wr_prio_q  <= '0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      wr_state_q <= wr_state_d;
      rd_gnt_q   <= rd_gnt_d;
      rd_prio_q  <= rd_prio_d;
      wr_gnt_q   <= wr_gnt_d;
      wr_prio_q  <= wr_prio_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
    end
  end

  always_comb begin
    rd_state_d = rd_state_q;
    rd_gnt_d   = rd_gnt_q;
    rd_prio_d  = rd_prio_q;
    wr_state_d = wr_state_q;
    wr_gnt_d   = wr_gnt_q;
    wr_prio_d  = wr_prio_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;

    unique case (rd_state_q)
      R_IDLE: if (rd_any) begin
        rd_gnt_d   = rd_pick;
        rd_state_d = R_ADDR;
      end
      R_ADDR: if (ar_hs) rd_state_d = R_DATA;
      R_DATA: if (r_last_hs) begin
        rd_state_d = R_IDLE;
        rd_prio_d  = IdxW'(rr_next_idx(arb_idx_t'(rd_gnt_q), int'(NrMasters)));
      end
      default: rd_state_d = R_IDLE;
    endcase

    unique case (wr_state_q)
      W_IDLE: if (wr_any) begin
        wr_gnt_d   = wr_pick;
        aw_done_d  = 1'b0;
        w_done_d   = 1'b0;
        wr_state_d = W_FWD;
      end
      W_FWD: begin
        // AW and last-W may finish in either order or together.
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q | w_last_hs;
        if (aw_done_d && w_done_d) wr_state_d = W_RESP;
      end
      W_RESP: if (b_hs) begin
        wr_state_d = W_IDLE;
        wr_prio_d  = IdxW'(rr_next_idx(arb_idx_t'(wr_gnt_q), int'(NrMasters)));
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    mst_req_o          = '0;
    mst_req_o.ar       = rd_req_s.ar;
    mst_req_o.ar_valid = rd_addr_ph & rd_req_s.ar_valid;
    mst_req_o.r_ready  = rd_data_ph & rd_req_s.r_ready;
    mst_req_o.aw       = wr_req_s.aw;
    mst_req_o.aw_valid = wr_fwd_ph & ~aw_done_q & wr_req_s.aw_valid;
    mst_req_o.w        = wr_req_s.w;
    mst_req_o.w_valid  = wr_fwd_ph & ~w_done_q & wr_req_s.w_valid;
    mst_req_o.b_ready  = wr_resp_ph & wr_req_s.b_ready;

    // Payloads are broadcast; only the lock owner sees handshake signals.
    for (int i = 0; i < NrMasters; i++) begin
      slv_resp_o[i]          = '0;
      slv_resp_o[i].b        = mst_resp_i.b;
      slv_resp_o[i].r        = mst_resp_i.r;
      slv_resp_o[i].ar_ready = (rd_gnt_q == IdxW'(i)) & rd_addr_ph & mst_resp_i.ar_ready;
      slv_resp_o[i].r_valid  = (rd_gnt_q == IdxW'(i)) & rd_data_ph & mst_resp_i.r_valid;
      slv_resp_o[i].aw_ready = (wr_gnt_q == IdxW'(i)) & wr_fwd_ph & ~aw_done_q
                               & mst_resp_i.aw_ready;
      slv_resp_o[i].w_ready  = (wr_gnt_q == IdxW'(i)) & wr_fwd_ph & ~w_done_q
                               & mst_resp_i.w_ready;
      slv_resp_o[i].b_valid  = (wr_gnt_q == IdxW'(i)) & wr_resp_ph & mst_resp_i.b_valid;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(mst_resp_i.b_valid && wr_state_q != W_RESP))
        else $warning("stray b_valid from downstream with no write response pending");
      assert (!(mst_resp_i.r_valid && rd_state_q != R_DATA))
        else $warning("stray r_valid from downstream with no read burst pending");
    end
  end

endmodule

// File: tb/tb_axi_lock_arbiter.sv
// Directed bench for axi_lock_arbiter with two requesters; R data and B
// responses go through an expected-value queue.
module tb_axi_lock_arbiter;
  import ariane_axi::*;

  localparam int N = 2;

  logic clk = 1'b0;
  logic rst;
  req_t  [N-1:0] slv_req;
  resp_t [N-1:0] slv_resp;
  req_t          mst_req;
  resp_t         mst_resp;
  logic          rd_busy, wr_busy;

  int vectors     = 0;
  int miscompares = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  axi_lock_arbiter #(.NrMasters(N)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .slv_req_i  (slv_req),
    .slv_resp_o (slv_resp),
    .mst_req_o  (mst_req),
    .mst_resp_i (mst_resp),
    .rd_busy_o  (rd_busy),
    .wr_busy_o  (wr_busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sb_check(input string tag, input logic [63:0] obs);
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL %s: observed %0h expected <queue empty>", tag, obs);
    end else begin
      check(tag, obs, exp_q.pop_front());
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for the AR to appear downstream and checks the grant.
  task automatic rd_addr(input int owner, input logic [3:0] exp_id, input logic [7:0] exp_len);
    bit found;
    int waited;
    found  = 1'b0;
    waited = 0;
    while (!found && waited < 20) begin
      @(negedge clk);
      if (mst_req.ar_valid === 1'b1) found = 1'b1;
      else begin
        next_cycle();
        waited++;
      end
    end
    check("ar_grant_seen", 64'(found), 64'd1);
    check("ar_id", 64'(mst_req.ar.id), 64'(exp_id));
    check("ar_len", 64'(mst_req.ar.len), 64'(exp_len));
    check("ar_ready_owner", 64'(slv_resp[owner].ar_ready), 64'd1);
    check("ar_ready_other", 64'(slv_resp[1-owner].ar_ready), 64'd0);
    check("rd_busy_addr", 64'(rd_busy), 64'd1);
    next_cycle();
  endtask

  task automatic r_beat(input int owner, input logic last);
    logic [63:0] d;
    d = {$urandom, $urandom};
    mst_resp.r_valid          = 1'b1;
    mst_resp.r.data           = d;
    mst_resp.r.last           = last;
    slv_req[owner].r_ready    = 1'b1;
    slv_req[1-owner].r_ready  = 1'b0;
    exp_q.push_back(d);
    @(negedge clk);
    check("r_valid_owner", 64'(slv_resp[owner].r_valid), 64'd1);
    check("r_valid_other", 64'(slv_resp[1-owner].r_valid), 64'd0);
    check("r_ready_fwd", 64'(mst_req.r_ready), 64'd1);
    sb_check("r_data", slv_resp[owner].r.data);
    next_cycle();
    mst_resp.r_valid       = 1'b0;
    mst_resp.r.last        = 1'b0;
    slv_req[owner].r_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] d0, d1, dr;
    int owner;

    // Reset with requests and responses active: everything must stay quiet.
    rst      = 1'b1;
    slv_req  = '0;
    mst_resp = '0;
    slv_req[0].ar_valid = 1'b1;
    slv_req[0].r_ready  = 1'b1;
    slv_req[1].aw_valid = 1'b1;
    slv_req[1].w_valid  = 1'b1;
    mst_resp.ar_ready   = 1'b1;
    mst_resp.r_valid    = 1'b1;
    repeat (2) next_cycle();
    @(negedge clk);
    check("rst_rd_busy", 64'(rd_busy), 64'd0);
    check("rst_wr_busy", 64'(wr_busy), 64'd0);
    check("rst_ar_valid", 64'(mst_req.ar_valid), 64'd0);
    check("rst_aw_valid", 64'(mst_req.aw_valid), 64'd0);
    check("rst_w_valid", 64'(mst_req.w_valid), 64'd0);
    check("rst_r_ready", 64'(mst_req.r_ready), 64'd0);
    check("rst_r_valid0", 64'(slv_resp[0].r_valid), 64'd0);
    check("rst_ar_ready0", 64'(slv_resp[0].ar_ready), 64'd0);
    next_cycle();
    slv_req  = '0;
    mst_resp = '0;
    mst_resp.ar_ready = 1'b1;
    mst_resp.w_ready  = 1'b1;
    rst = 1'b0;

    // Single read from master 1, id 3, four beats.
    slv_req[1].ar.id    = 4'd3;
    slv_req[1].ar.len   = 8'd3;
    slv_req[1].ar.addr  = 64'h1000;
    slv_req[1].ar_valid = 1'b1;
    @(negedge clk);
    check("single_ar_latency", 64'(mst_req.ar_valid), 64'd0);
    check("single_idle_busy", 64'(rd_busy), 64'd0);
    next_cycle();
    rd_addr(1, 4'd3, 8'd3);
    slv_req[1].ar_valid = 1'b0;
    for (int b = 0; b < 4; b++) r_beat(1, (b == 3));
    @(negedge clk);
    check("single_busy_after_last", 64'(rd_busy), 64'd0);
    next_cycle();

    // Contention from reset exit: grants alternate 0,1,0,1.
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    slv_req[0].ar.id  = 4'd4;
    slv_req[0].ar.len = 8'd0;
    slv_req[1].ar.id  = 4'd9;
    slv_req[1].ar.len = 8'd0;
    slv_req[0].ar_valid = 1'b1;
    slv_req[1].ar_valid = 1'b1;
    next_cycle();
    for (int k = 0; k < 4; k++) begin
      owner = k % 2;
      rd_addr(owner, (owner == 0) ? 4'd4 : 4'd9, 8'd0);
      r_beat(owner, 1'b1);
      @(negedge clk);
      check("contend_gap_ar_valid", 64'(mst_req.ar_valid), 64'd0);
      check("contend_gap_busy", 64'(rd_busy), 64'd0);
      if (k == 3) begin
        slv_req[0].ar_valid = 1'b0;
        slv_req[1].ar_valid = 1'b0;
      end
      next_cycle();
    end

    // Write from master 1: both W beats complete before AW is accepted.
    d0 = 64'h0123_4567_89ab_cdef;
    d1 = 64'hfedc_ba98_7654_3210;
    mst_resp.aw_ready   = 1'b0;
    slv_req[1].aw.id    = 4'd5;
    slv_req[1].aw.len   = 8'd1;
    slv_req[1].aw_valid = 1'b1;
    slv_req[1].w.data   = d0;
    slv_req[1].w.last   = 1'b0;
    slv_req[1].w_valid  = 1'b1;
    slv_req[0].b_ready  = 1'b1;
    slv_req[1].b_ready  = 1'b1;
    @(negedge clk);
    check("wr_aw_latency", 64'(mst_req.aw_valid), 64'd0);
    check("wr_idle_busy", 64'(wr_busy), 64'd0);
    next_cycle();
    @(negedge clk);
    check("wr_w_valid_b0", 64'(mst_req.w_valid), 64'd1);
    check("wr_w_data_b0", mst_req.w.data, d0);
    check("wr_aw_valid", 64'(mst_req.aw_valid), 64'd1);
    check("wr_aw_id", 64'(mst_req.aw.id), 64'd5);
    check("wr_w_ready_owner", 64'(slv_resp[1].w_ready), 64'd1);
    check("wr_w_ready_other", 64'(slv_resp[0].w_ready), 64'd0);
    check("wr_aw_ready_held", 64'(slv_resp[1].aw_ready), 64'd0);
    check("wr_busy_fwd", 64'(wr_busy), 64'd1);
    next_cycle();
    slv_req[1].w.data = d1;
    slv_req[1].w.last = 1'b1;
    @(negedge clk);
    check("wr_w_data_b1", mst_req.w.data, d1);
    check("wr_w_last_b1", 64'(mst_req.w.last), 64'd1);
    next_cycle();
    @(negedge clk);
    check("wr_w_gated", 64'(mst_req.w_valid), 64'd0);
    check("wr_not_resp_yet", 64'(mst_req.b_ready), 64'd0);
    check("wr_aw_still_valid", 64'(mst_req.aw_valid), 64'd1);
    next_cycle();
    mst_resp.aw_ready = 1'b1;
    @(negedge clk);
    check("wr_aw_ready_owner", 64'(slv_resp[1].aw_ready), 64'd1);
    check("wr_b_ready_before_aw", 64'(mst_req.b_ready), 64'd0);
    next_cycle();
    slv_req[1].aw_valid = 1'b0;
    slv_req[1].w_valid  = 1'b0;
    mst_resp.b_valid    = 1'b1;
    mst_resp.b.id       = 4'd5;
    mst_resp.b.resp     = RESP_OKAY;
    exp_q.push_back(64'({4'd5, RESP_OKAY}));
    @(negedge clk);
    check("wr_b_ready_fwd", 64'(mst_req.b_ready), 64'd1);
    check("wr_aw_gated", 64'(mst_req.aw_valid), 64'd0);
    check("wr_b_valid_owner", 64'(slv_resp[1].b_valid), 64'd1);
    check("wr_b_valid_other", 64'(slv_resp[0].b_valid), 64'd0);
    sb_check("wr_b_idresp", 64'({slv_resp[1].b.id, slv_resp[1].b.resp}));
    next_cycle();
    mst_resp.b_valid = 1'b0;
    @(negedge clk);
    check("wr_busy_done", 64'(wr_busy), 64'd0);
    next_cycle();

    // Concurrent: master 0 writes while master 1 reads.
    slv_req = '0;
    dr = 64'hdead_beef_0bad_f00d;
    slv_req[0].aw.id    = 4'd2;
    slv_req[0].aw_valid = 1'b1;
    slv_req[0].w.data   = d0;
    slv_req[0].w.last   = 1'b1;
    slv_req[0].w_valid  = 1'b1;
    slv_req[1].ar.id    = 4'd7;
    slv_req[1].ar_valid = 1'b1;
    @(negedge clk);
    check("conc_idle_rd", 64'(rd_busy), 64'd0);
    check("conc_idle_wr", 64'(wr_busy), 64'd0);
    next_cycle();
    @(negedge clk);
    check("conc_ar_valid", 64'(mst_req.ar_valid), 64'd1);
    check("conc_ar_id", 64'(mst_req.ar.id), 64'd7);
    check("conc_aw_valid", 64'(mst_req.aw_valid), 64'd1);
    check("conc_aw_id", 64'(mst_req.aw.id), 64'd2);
    check("conc_w_valid", 64'(mst_req.w_valid), 64'd1);
    check("conc_aw_ready0", 64'(slv_resp[0].aw_ready), 64'd1);
    check("conc_aw_ready1", 64'(slv_resp[1].aw_ready), 64'd0);
    check("conc_ar_ready1", 64'(slv_resp[1].ar_ready), 64'd1);
    check("conc_ar_ready0", 64'(slv_resp[0].ar_ready), 64'd0);
    next_cycle();
    slv_req = '0;
    slv_req[1].r_ready = 1'b1;
    slv_req[0].b_ready = 1'b1;
    mst_resp.r_valid = 1'b1;
    mst_resp.r.data  = dr;
    mst_resp.r.last  = 1'b1;
    mst_resp.b_valid = 1'b1;
    mst_resp.b.id    = 4'd2;
    mst_resp.b.resp  = RESP_OKAY;
    exp_q.push_back(dr);
    exp_q.push_back(64'({4'd2, RESP_OKAY}));
    @(negedge clk);
    check("conc_r_valid1", 64'(slv_resp[1].r_valid), 64'd1);
    check("conc_r_valid0", 64'(slv_resp[0].r_valid), 64'd0);
    check("conc_b_valid0", 64'(slv_resp[0].b_valid), 64'd1);
    check("conc_b_valid1", 64'(slv_resp[1].b_valid), 64'd0);
    sb_check("conc_r_data", slv_resp[1].r.data);
    sb_check("conc_b_idresp", 64'({slv_resp[0].b.id, slv_resp[0].b.resp}));
    next_cycle();
    mst_resp.r_valid = 1'b0;
    mst_resp.r.last  = 1'b0;
    mst_resp.b_valid = 1'b0;
    slv_req = '0;
    @(negedge clk);
    check("conc_rd_done", 64'(rd_busy), 64'd0);
    check("conc_wr_done", 64'(wr_busy), 64'd0);
    next_cycle();

    // Advance the read pointer to 1 so the reset clear is observable.
    slv_req[0].ar.id    = 4'd1;
    slv_req[0].ar_valid = 1'b1;
    next_cycle();
    rd_addr(0, 4'd1, 8'd0);
    slv_req[0].ar_valid = 1'b0;
    r_beat(0, 1'b1);
    @(negedge clk);
    check("pre_rst_idle", 64'(rd_busy), 64'd0);
    next_cycle();

    // Reset after two of four beats of a master 1 burst.
    slv_req[1].ar.id    = 4'd3;
    slv_req[1].ar.len   = 8'd3;
    slv_req[1].ar_valid = 1'b1;
    next_cycle();
    rd_addr(1, 4'd3, 8'd3);
    slv_req[1].ar_valid = 1'b0;
    r_beat(1, 1'b0);
    r_beat(1, 1'b0);
    rst = 1'b1;
    slv_req[0].ar_valid = 1'b1;
    slv_req[1].ar_valid = 1'b1;
    slv_req[1].r_ready  = 1'b1;
    mst_resp.r_valid    = 1'b1;
    @(negedge clk);
    check("midrst_busy_now", 64'(rd_busy), 64'd0);
    check("midrst_r_valid_now", 64'(slv_resp[1].r_valid), 64'd0);
    next_cycle();
    @(negedge clk);
    check("midrst_busy", 64'(rd_busy), 64'd0);
    check("midrst_r_valid", 64'(slv_resp[1].r_valid), 64'd0);
    check("midrst_r_ready", 64'(mst_req.r_ready), 64'd0);
    check("midrst_ar_valid", 64'(mst_req.ar_valid), 64'd0);
    next_cycle();
    rst = 1'b0;
    mst_resp.r_valid   = 1'b0;
    slv_req[1].r_ready = 1'b0;
    next_cycle();
    rd_addr(0, 4'd1, 8'd0);
    slv_req[0].ar_valid = 1'b0;
    slv_req[1].ar_valid = 1'b0;
    r_beat(0, 1'b1);
    @(negedge clk);
    check("postrst_idle", 64'(rd_busy), 64'd0);
    next_cycle();

    // Stray B with no write outstanding.
    slv_req[0].b_ready = 1'b1;
    slv_req[1].b_ready = 1'b1;
    mst_resp.b_valid   = 1'b1;
    @(negedge clk);
    check("stray_b_ready", 64'(mst_req.b_ready), 64'd0);
    check("stray_b_valid0", 64'(slv_resp[0].b_valid), 64'd0);
    check("stray_b_valid1", 64'(slv_resp[1].b_valid), 64'd0);
    check("stray_wr_busy", 64'(wr_busy), 64'd0);
    next_cycle();
    mst_resp.b_valid = 1'b0;
    slv_req = '0;
    next_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
